bram_reduce: RTL and testbench

- Parametrised successor to the PL max-finder.
- Scans a PS-programmed window of words in a shared BRAM and reduces it to one extreme value: unsigned/signed max or min.
- Writes the value, then the absolute word index of the winner, back to BRAM words 0 and 1.
- Sits between the PS GPIO control/status registers and the PL port of an AXI BRAM controller; same four-phase level handshake as the existing block.

---
 rtl/bram_reduce.sv | 226 ++++++++++++++++++++++
 tb/tb_bram_reduce.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_reduce.sv
// bram_reduce: scans a window of BRAM words and writes the extreme value
// (unsigned/signed max or min) to word 0 and the winner's word index to word 1.
// Optional build macro BRAM_REDUCE_SUM_EN: ps_control[3] selects a modulo-2^DATA_W
// sum of the window instead, with N written to word 1.
module bram_reduce #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           ps_control,
  input  logic [31:0]           ps_window,
  output logic [31:0]           pl_status,
  output logic [ADDR_W-1:0]     bram_addr,
  input  logic [DATA_W-1:0]     bram_rddata,
  output logic [DATA_W-1:0]     bram_wrdata,
  output logic [DATA_W/8-1:0]   bram_we
);

  localparam int WA_W = ADDR_W - 2;
  localparam int BE_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_WR_VAL = 3'd2;
  localparam logic [2:0] S_WR_IDX = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0]       ST_BUSY  = 32'h0000_0002;
  localparam logic [31:0]       ST_DONE  = 32'h0000_0001;
  localparam logic [ADDR_W-1:0] ADDR_IDX = ADDR_W'(4);
  localparam logic [BE_W-1:0]   WE_ALL   = {BE_W{1'b1}};

  // Strict comparison for the selected mode; ties never replace the winner.
  function automatic logic f_better(input logic [1:0] mode,
                                    input logic [DATA_W-1:0] cand,
                                    input logic [DATA_W-1:0] best);
    logic signed [DATA_W-1:0] s_cand;
    logic signed [DATA_W-1:0] s_best;
    s_cand = cand;
    s_best = best;
    case (mode)
      2'b00:   f_better = (cand > best);
      2'b01:   f_better = (cand < best);
      2'b10:   f_better = (s_cand > s_best);
      default: f_better = (s_cand < s_best);
    endcase
  endfunction

  // Result reported for an empty window.
  function automatic logic [DATA_W-1:0] f_identity(input logic [1:0] mode);
    case (mode)
      2'b00:   f_identity = '0;
      2'b01:   f_identity = '1;
      2'b10:   f_identity = {1'b1, {(DATA_W-1){1'b0}}};
      default: f_identity = {1'b0, {(DATA_W-1){1'b1}}};
    endcase
  endfunction

  logic [2:0]          r_state;
  logic [31:0]         r_status;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wrdata;
  logic [BE_W-1:0]     r_we;
  logic [1:0]          r_mode;
  logic [15:0]         r_count;
  logic [16:0]         r_issued;
  logic [16:0]         r_cmp_k;
  logic [WA_W-1:0]     r_next_word;
  logic                r_vld_p0;
  logic                r_vld_p1;
  logic [WA_W-1:0]     r_idx_p0;
  logic [WA_W-1:0]     r_idx_p1;
  logic [DATA_W-1:0]   r_best;
  logic [DATA_W-1:0]   r_best_idx;

  logic                w_start;
  logic                w_issue;
  logic                w_last;
  logic [DATA_W-1:0]   w_best_nxt;
  logic [DATA_W-1:0]   w_idx_nxt;
  logic [DATA_W-1:0]   w_empty_val;
  logic [DATA_W-1:0]   w_idx_word;
  logic                w_unused;

`ifdef BRAM_REDUCE_SUM_EN
  logic                r_sum;
  assign w_unused = &{1'b0, ps_control[31:4], ps_window[31:16]};
`else
  assign w_unused = &{1'b0, ps_control[31:3], ps_window[31:16]};
`endif

  assign w_start = (r_state == S_IDLE) && ps_control[0];
  assign w_issue = (r_state == S_SCAN) && (r_issued < {1'b0, r_count});
  assign w_last  = r_vld_p1 && ((r_cmp_k + 17'd1) == {1'b0, r_count});

`ifdef BRAM_REDUCE_SUM_EN
  assign w_empty_val = ps_control[3] ? '0 : f_identity(ps_control[2:1]);
  assign w_idx_word  = r_sum ? DATA_W'(r_count) : r_best_idx;
`else
  assign w_empty_val = f_identity(ps_control[2:1]);
  assign w_idx_word  = r_best_idx;
`endif

  // Fold the word returning from BRAM into the running result.
  always_comb begin
    w_best_nxt = r_best;
    w_idx_nxt  = r_best_idx;
    if (r_vld_p1 && ((r_cmp_k == 17'd0) || f_better(r_mode, bram_rddata, r_best))) begin
      w_best_nxt = bram_rddata;
      w_idx_nxt  = DATA_W'(r_idx_p1);
    end
`ifdef BRAM_REDUCE_SUM_EN
    if (r_sum) begin
      w_best_nxt = r_vld_p1 ? (r_best + bram_rddata) : r_best;
      w_idx_nxt  = r_best_idx;
    end
`endif
  end

  // Control FSM and registered BRAM/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_status <= '0;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_we     <= '0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_issued <= '0;
      r_cmp_k  <= '0;
    end else begin
      // p0 -> p1: address on the bus becomes read data next cycle
      r_vld_p1 <= r_vld_p0;
      r_vld_p0 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ps_control[0]) begin
            r_status <= ST_BUSY;
            r_cmp_k  <= '0;
            if (ps_window[15:0] == 16'd0) begin
              r_state  <= S_WR_VAL;
              r_addr   <= '0;
              r_we     <= WE_ALL;
              r_wrdata <= w_empty_val;
            end else begin
              r_state  <= S_SCAN;
              r_addr   <= {ps_window[16 +: WA_W], 2'b00};
              r_vld_p0 <= 1'b1;
              r_issued <= 17'd1;
            end
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            r_addr   <= {r_next_word, 2'b00};
            r_vld_p0 <= 1'b1;
            r_issued <= r_issued + 17'd1;
          end
          if (r_vld_p1) begin
            r_cmp_k <= r_cmp_k + 17'd1;
          end
          if (w_last) begin
            r_state  <= S_WR_VAL;
            r_addr   <= '0;
            r_we     <= WE_ALL;
            r_wrdata <= w_best_nxt;
          end
        end
        S_WR_VAL: begin
          r_state  <= S_WR_IDX;
          r_addr   <= ADDR_IDX;
          r_we     <= WE_ALL;
          r_wrdata <= w_idx_word;
        end
        S_WR_IDX: begin
          r_state  <= S_DONE;
          r_addr   <= '0;
          r_we     <= '0;
          r_status <= ST_DONE;
        end
        S_DONE: begin
          if (!ps_control[0]) begin
            r_state  <= S_IDLE;
            r_status <= '0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_status <= '0;
          r_we     <= '0;
        end
      endcase
    end
  end

  // Operation parameters, address walker and reduction datapath.
  always_ff @(posedge clk) begin
    r_idx_p1 <= r_idx_p0;
    if (w_start) begin
      r_mode      <= ps_control[2:1];
      r_count     <= ps_window[15:0];
      r_idx_p0    <= ps_window[16 +: WA_W];
      r_next_word <= ps_window[16 +: WA_W] + WA_W'(1);
      r_best      <= '0;
      r_best_idx  <= '1;
`ifdef BRAM_REDUCE_SUM_EN
      r_sum       <= ps_control[3];
`endif
    end else if (r_state == S_SCAN) begin
      if (w_issue) begin
        r_idx_p0    <= r_next_word;
        r_next_word <= r_next_word + WA_W'(1);
      end
      r_best     <= w_best_nxt;
      r_best_idx <= w_idx_nxt;
    end
  end

  assign pl_status   = r_status;
  assign bram_addr   = r_addr;
  assign bram_wrdata = r_wrdata;
  assign bram_we     = r_we;

endmodule

// File: tb/tb_bram_reduce.sv
// Testbench for bram_reduce: BRAM model with one-cycle read latency, a
// list-based reference model of the reduction, directed and random operations.
module tb_bram_reduce;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 2048;
  localparam int LIMIT  = 70000;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       ps_control;
  logic [31:0]       ps_window;
  logic [31:0]       pl_status;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rddata;
  logic [DATA_W-1:0] bram_wrdata;
  logic [3:0]        bram_we;

  logic [31:0] mem  [0:DEPTH-1];
  logic [31:0] snap [0:DEPTH-1];
  logic        ld_en;
  logic [10:0] ld_addr;
  logic [31:0] ld_data;

  int tests = 0;
  int fails = 0;

  bram_reduce #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .ps_control(ps_control), .ps_window(ps_window),
    .pl_status(pl_status), .bram_addr(bram_addr), .bram_rddata(bram_rddata),
    .bram_wrdata(bram_wrdata), .bram_we(bram_we)
  );

  always #5 clk = ~clk;

  // BRAM: registered read, byte-enabled write, plus a bench preload port
  always @(posedge clk) begin
    bram_rddata <= mem[bram_addr[12:2]];
    if (ld_en) mem[ld_addr] <= ld_data;
    else begin
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[12:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 11'(a); ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Reference: walk the window as a list and keep the first strict winner
  function automatic void model(input logic [1:0] mode, input bit sum_act,
                                input int s, input int n,
                                output logic [31:0] val, output logic [31:0] idx);
    logic [31:0] v;
    bit better;
    if (sum_act) begin
      val = 0;
      for (int k = 0; k < n; k++) val = val + snap[(s + k) % DEPTH];
      idx = 32'(n);
      return;
    end
    case (mode)
      2'd0: val = 32'h0000_0000;
      2'd1: val = 32'hffff_ffff;
      2'd2: val = 32'h8000_0000;
      default: val = 32'h7fff_ffff;
    endcase
    idx = 32'hffff_ffff;
    for (int k = 0; k < n; k++) begin
      v = snap[(s + k) % DEPTH];
      case (mode)
        2'd0: better = v > val;
        2'd1: better = v < val;
        2'd2: better = $signed(v) > $signed(val);
        default: better = $signed(v) < $signed(val);
      endcase
      if (k == 0 || better) begin
        val = v;
        idx = 32'((s + k) % DEPTH);
      end
    end
  endfunction

  task automatic run_op(input string tag, input logic [1:0] mode, input bit sum,
                        input int s, input int n, input bit scramble);
    logic [31:0] ev, ei, ga, ea;
    logic [12:0] qa[$];
    logic [3:0]  qw[$];
    logic [31:0] qs[$];
    int cyc, done_cyc, exp_done, wv;
    bit sum_act, found;
    for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
`ifdef BRAM_REDUCE_SUM_EN
    sum_act = sum;
`else
    sum_act = 1'b0;
`endif
    model(mode, sum_act, s, n, ev, ei);
    exp_done = (n == 0) ? 3 : n + 4;
    @(negedge clk);
    ps_control = {28'd0, sum, mode, 1'b1};
    ps_window  = {s[15:0], n[15:0]};
    cyc = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < LIMIT) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      qa.push_back(bram_addr); qw.push_back(bram_we); qs.push_back(pl_status);
      if (pl_status[0]) done_cyc = cyc;
      if (scramble && cyc == 2) begin
        ps_control[3:1] = ~ps_control[3:1];
        ps_window = $urandom;
      end
    end
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    if (done_cyc == exp_done) begin
      ga = 0; ea = 0; found = 0;
      for (int k = 0; k < n; k++) begin
        if (!found) begin
          ga = 32'(qa[k]);
          ea = 32'(((s + k) % DEPTH) * 4);
          if (ga !== ea) found = 1;
        end
      end
      if (n > 0) begin
        chk({tag, " read_addr_seq"}, ga, ea);
        chk({tag, " busy_cycle1"}, qs[0], 32'h2);
      end
      wv = (n == 0) ? 1 : n + 2;
      chk({tag, " wrval_addr"}, 32'(qa[wv-1]), 32'd0);
      chk({tag, " wrval_we"},   32'(qw[wv-1]), 32'hf);
      chk({tag, " wridx_addr"}, 32'(qa[wv]),   32'd4);
      chk({tag, " wridx_we"},   32'(qw[wv]),   32'hf);
      chk({tag, " done_status"}, qs[done_cyc-1], 32'h1);
      chk({tag, " done_we"},    32'(qw[done_cyc-1]), 32'h0);
    end
    chk({tag, " word0"}, mem[0], ev);
    chk({tag, " word1"}, mem[1], ei);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " hold_done"}, pl_status, 32'h1);
    end
    ps_control[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, " clear"}, pl_status, 32'h0);
    @(posedge clk); @(negedge clk);
    chk({tag, " idle"}, pl_status, 32'h0);
  endtask

  initial begin
    logic [31:0] v, keep0, keep1;
    logic [31:0] pool [0:4];
    int s, n;
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h7fffffff;
    pool[3] = 32'h80000000; pool[4] = 32'hffffffff;
    reset = 1'b1; ps_control = 0; ps_window = 0;
    ld_en = 1'b0; ld_addr = 0; ld_data = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      if (v == 32'hffffffff) v = 32'h0;
      if (i == DEPTH - 1) v = 32'hffffffff;
      poke(i, v);
    end
    @(negedge clk);
    chk("reset status", pl_status, 32'h0);
    chk("reset addr", 32'(bram_addr), 32'h0);
    chk("reset we", 32'(bram_we), 32'h0);
    chk("reset wrdata", bram_wrdata, 32'h0);
    reset = 1'b0;

    run_op("full_umax", 2'b00, 1'b0, 0, 2048, 1'b0);
    chk("full_umax word0 const", mem[0], 32'hffffffff);
    chk("full_umax word1 const", mem[1], 32'd2047);

    poke(10, 32'd5); poke(11, 32'h80000000); poke(12, 32'd7); poke(13, 32'h80000000);
    run_op("tie_smin", 2'b11, 1'b0, 10, 4, 1'b0);
    chk("tie_smin word0 const", mem[0], 32'h80000000);
    chk("tie_smin word1 const", mem[1], 32'd11);
    run_op("tie_umax", 2'b00, 1'b0, 10, 4, 1'b0);
    chk("tie_umax word1 const", mem[1], 32'd11);

    poke(2046, 32'd3); poke(2047, 32'd9); poke(0, 32'd1); poke(1, 32'd9);
    run_op("wrap_umin", 2'b01, 1'b0, 2046, 4, 1'b0);
    chk("wrap_umin word0 const", mem[0], 32'd1);
    chk("wrap_umin word1 const", mem[1], 32'd0);

    run_op("empty_smax", 2'b10, 1'b0, 5, 0, 1'b0);
    chk("empty_smax word0 const", mem[0], 32'h80000000);
    chk("empty_smax word1 const", mem[1], 32'hffffffff);

    keep0 = mem[0]; keep1 = mem[1];
    @(negedge clk);
    ps_control = 32'h1; ps_window = {16'd0, 16'd100};
    repeat (5) begin @(posedge clk); @(negedge clk); end
    chk("abort busy", pl_status, 32'h2);
    reset = 1'b1; ps_control = 32'h0;
    @(posedge clk); @(negedge clk);
    chk("abort status", pl_status, 32'h0);
    chk("abort we", 32'(bram_we), 32'h0);
    chk("abort addr", 32'(bram_addr), 32'h0);
    reset = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("abort word0 kept", mem[0], keep0);
    chk("abort word1 kept", mem[1], keep1);
    run_op("after_abort", 2'b10, 1'b0, 300, 17, 1'b0);

    poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3); poke(3, 32'hffffffff);
    run_op("sum_sel", 2'b00, 1'b1, 0, 4, 1'b0);
`ifdef BRAM_REDUCE_SUM_EN
    chk("sum_sel word0 const", mem[0], 32'd5);
    chk("sum_sel word1 const", mem[1], 32'd4);
`else
    chk("sum_sel word0 const", mem[0], 32'hffffffff);
    chk("sum_sel word1 const", mem[1], 32'd3);
`endif

    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) begin
        v = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
        poke((s + k) % DEPTH, v);
      end
      run_op($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), 1'b0, s, n, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
